// File: rtl/multi_compuerta_pkg.sv
// Shared mode encoding for the pipelined multi-gate network.
package multi_compuerta_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_GATE  = 2'd0;
    localparam mode_t MODE_ANDOR = 2'd1;
    localparam mode_t MODE_XOR   = 2'd2;
    localparam mode_t MODE_NEG   = 2'd3;

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready register stage. It accepts whenever it is empty or draining,
// so an empty slot is overwritten by the stage behind it (bubble collapse).
module pipe_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            // Keep the last payload through bubbles so idle outputs do not toggle.
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/multi_compuerta_pipe.sv
// Two-stage valid/ready pipeline evaluating one of four bitwise gate networks,
// with a wrapping count of delivered results.
module multi_compuerta_pipe
    import multi_compuerta_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    input  mode_t              mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   x,
    output logic [WIDTH-1:0]   y,
    output logic               x_any,
    output logic               y_all,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] done_count
);

    // t0/t1/t2 hold e/f/h in GATE mode and the two partial terms otherwise.
    typedef struct packed {
        mode_t             mode;
        logic [WIDTH-1:0]  t0;
        logic [WIDTH-1:0]  t1;
        logic [WIDTH-1:0]  t2;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0]  x;
        logic [WIDTH-1:0]  y;
        logic              x_any;
        logic              y_all;
    } s2_t;

    s1_t              s1_in;
    s1_t              s1_out;
    s2_t              s2_in;
    s2_t              s2_out;
    logic             s1_valid;
    logic             s2_adv;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [COUNT_W-1:0] done_count_q;

    always_comb begin
        s1_in      = '0;
        s1_in.mode = mode;
        unique case (mode)
            MODE_GATE: begin
                s1_in.t0 = a & b;
                s1_in.t1 = (a & b) | c;
                s1_in.t2 = c & d;
            end
            MODE_ANDOR: begin
                s1_in.t0 = a & b;
                s1_in.t1 = c | d;
            end
            MODE_XOR: begin
                s1_in.t0 = a ^ b;
                s1_in.t1 = c ^ d;
            end
            MODE_NEG: begin
                s1_in.t0 = a & b;
                s1_in.t1 = c | d;
            end
        endcase
    end

    pipe_stage #(
        .DATA_W ($bits(s1_t))
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_adv),
        .out_data  (s1_out)
    );

    always_comb begin
        x_d = '0;
        y_d = '0;
        unique case (s1_out.mode)
            MODE_GATE: begin
                x_d = ~s1_out.t1 | s1_out.t2;
                y_d = s1_out.t2;
            end
            MODE_ANDOR: begin
                x_d = s1_out.t0;
                y_d = s1_out.t1;
            end
            MODE_XOR: begin
                x_d = s1_out.t0;
                y_d = ~s1_out.t1;
            end
            MODE_NEG: begin
                x_d = ~s1_out.t0;
                y_d = ~s1_out.t1;
            end
        endcase
        s2_in.x     = x_d;
        s2_in.y     = y_d;
        s2_in.x_any = |x_d;
        s2_in.y_all = &y_d;
    end

    pipe_stage #(
        .DATA_W ($bits(s2_t))
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_adv),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign x     = s2_out.x;
    assign y     = s2_out.y;
    assign x_any = s2_out.x_any;
    assign y_all = s2_out.y_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count_q <= '0;
        end else if (out_valid & out_ready) begin
            done_count_q <= done_count_q + COUNT_W'(1);
        end
    end

    assign done_count = done_count_q;

endmodule

// File: tb/tb_multi_compuerta_pipe.sv
// Randomised and directed bench for multi_compuerta_pipe against an in-order result model.
module tb_multi_compuerta_pipe;
    import multi_compuerta_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
    mode_t         mode = MODE_GATE;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x, y;
    logic          x_any, y_all;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] done_count;

    multi_compuerta_pipe #(
        .WIDTH   (W),
        .COUNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .x_any      (x_any),
        .y_all      (y_all),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } res_t;

    res_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    int unsigned delivered = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic res_t ref_model(input mode_t m, input logic [W-1:0] ra, rb, rc, rd);
        res_t r;
        case (m)
            MODE_GATE: begin
                r.x = ~((ra & rb) | rc) | (rc & rd);
                r.y = rc & rd;
            end
            MODE_ANDOR: begin
                r.x = ra & rb;
                r.y = rc | rd;
            end
            MODE_XOR: begin
                r.x = ra ^ rb;
                r.y = ~(rc ^ rd);
            end
            default: begin
                r.x = ~(ra & rb);
                r.y = ~(rc | rd);
            end
        endcase
        return r;
    endfunction

    // One clock: drive at negedge, sample 1 ns later, score the transfers of the next posedge.
    task automatic cycle(input logic iv, input mode_t m, input logic [W-1:0] va, vb, vc, vd,
                         input logic ordy);
        res_t e;
        logic want_rdy;
        @(negedge clk);
        in_valid  = iv;
        mode      = m;
        a         = va;
        b         = vb;
        c         = vc;
        d         = vd;
        out_ready = ordy;
        #1;
        check_eq("done_count", 32'(done_count), 32'(delivered % (1 << CW)));
        want_rdy = !(exp_q.size() == 2 && !ordy);
        check_eq("in_ready", 32'(in_ready), 32'(want_rdy));
        if (exp_q.size() == 2) check_eq("out_valid_full", 32'(out_valid), 32'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("x", 32'(x), 32'(e.x));
                check_eq("y", 32'(y), 32'(e.y));
                check_eq("x_any", 32'(x_any), 32'(|e.x));
                check_eq("y_all", 32'(y_all), 32'(&e.y));
                delivered++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_model(m, va, vb, vc, vd));
    endtask

    task automatic rnd_cycle(input logic ordy);
        logic iv;
        iv = 1'($urandom_range(1, 0));
        cycle(iv, mode_t'($urandom_range(3, 0)), W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), ordy);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, MODE_GATE, '0, '0, '0, '0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) break;
            idle(1'b1);
        end
        check_eq("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_x", 32'(x), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_x_any", 32'(x_any), 32'd0);
        check_eq("rst_y_all", 32'(y_all), 32'd0);
        check_eq("rst_done_count", 32'(done_count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        delivered = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [W-1:0] hx, hy;
    int unsigned  c0;

    initial begin
        do_reset();

        // GATE mode directed vector, latency of two edges
        cycle(1'b1, MODE_GATE, 4'b1100, 4'b1010, 4'b0011, 4'b0101, 1'b1);
        idle(1'b1);
        check_eq("lat_gate_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        check_eq("gate_valid", 32'(out_valid), 32'd1);
        check_eq("gate_x", 32'(x), 32'b0101);
        check_eq("gate_y", 32'(y), 32'b0001);
        check_eq("gate_x_any", 32'(x_any), 32'd1);
        check_eq("gate_y_all", 32'(y_all), 32'd0);
        idle(1'b1);
        check_eq("gate_count", 32'(done_count), 32'd1);

        // Modes 1..3 back-to-back, one result per cycle
        cycle(1'b1, MODE_ANDOR, 4'b1100, 4'b1010, 4'b0011, 4'b0101, 1'b1);
        cycle(1'b1, MODE_XOR,   4'b1100, 4'b1010, 4'b0011, 4'b0101, 1'b1);
        cycle(1'b1, MODE_NEG,   4'b1100, 4'b1010, 4'b0011, 4'b0101, 1'b1);
        check_eq("andor_valid", 32'(out_valid), 32'd1);
        check_eq("andor_x", 32'(x), 32'b1000);
        check_eq("andor_y", 32'(y), 32'b0111);
        idle(1'b1);
        check_eq("xor_valid", 32'(out_valid), 32'd1);
        check_eq("xor_x", 32'(x), 32'b0110);
        check_eq("xor_y", 32'(y), 32'b1001);
        idle(1'b1);
        check_eq("neg_valid", 32'(out_valid), 32'd1);
        check_eq("neg_x", 32'(x), 32'b0111);
        check_eq("neg_y", 32'(y), 32'b1000);
        drain();

        // Fill both stages, stall ten cycles, then release
        idle(1'b1);
        c0 = delivered;
        rnd_cycle(1'b0);
        cycle(1'b1, MODE_XOR, 4'h3, 4'h5, 4'h6, 4'h9, 1'b0);
        cycle(1'b1, MODE_NEG, 4'h1, 4'h2, 4'h4, 4'h8, 1'b0);
        cycle(1'b1, MODE_ANDOR, 4'hf, 4'hf, 4'h0, 4'h0, 1'b0);
        hx = x;
        hy = y;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, MODE_GATE, 4'ha, 4'h5, 4'hc, 4'h3, 1'b0);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_x", 32'(x), 32'(hx));
            check_eq("stall_y", 32'(y), 32'(hy));
        end
        drain();
        idle(1'b1);
        check_eq("stall_count", 32'(done_count), 32'((c0 + exp_done_inc()) % (1 << CW)));

        // Random traffic
        for (int i = 0; i < 1000; i++) rnd_cycle(1'($urandom_range(1, 0)));
        drain();

        // Counter wrap at COUNT_W=4 after 17 results
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, mode_t'($urandom_range(3, 0)), W'($urandom), W'($urandom),
                  W'($urandom), W'($urandom), 1'b1);
        end
        drain();
        idle(1'b1);
        check_eq("wrap_count", 32'(done_count), 32'd1);

        // Reset with both stages full, then a clean first result
        cycle(1'b1, MODE_GATE, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        cycle(1'b1, MODE_XOR, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
        idle(1'b0);
        check_eq("prefill_valid", 32'(out_valid), 32'd1);
        do_reset();
        cycle(1'b1, MODE_XOR, 4'b1100, 4'b1010, 4'b0011, 4'b0101, 1'b1);
        idle(1'b1);
        check_eq("post_rst_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        check_eq("post_rst_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_x", 32'(x), 32'b0110);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // The stall section fills exactly two results (one random vector may or may not enter).
    int unsigned stall_pushes;
    function automatic int unsigned exp_done_inc();
        return delivered - c0;
    endfunction

endmodule
